// File: rtl/window_3x3_gen.sv
// window_3x3_gen
//   Turns a raster pixel stream into a sliding 3x3 neighbourhood. Two line
//   buffers hold the previous two lines; a 3x3 register array is shifted one
//   column per accepted pixel. A window is flagged only once the newest
//   pixel is at row>=2 and col>=2, so it never spans a line end, and every
//   line-buffer entry it uses was already written in the current frame.
//
//   Optional feature: define WIN_COORD_EN to add win_x_o/win_y_o (centre
//   pixel column/row of the current window).
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   pix_i          24-bit pixel {R,G,B}
//   pix_valid_i    pix_i accepted on this edge when high
//   sof_i          with pix_valid_i, marks pixel (0,0)
//   colour_o0..o8  window, row-major (o0 top-left, o4 centre, o8 bottom-right)
//   win_valid_o    window outputs valid this cycle
//   frame_done_o   pulses with the last window of the frame
//   win_x_o/win_y_o  (WIN_COORD_EN only) centre column/row of the window
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pix_i,
  input  logic        pix_valid_i,
  input  logic        sof_i,
  output logic [23:0] colour_o0,
  output logic [23:0] colour_o1,
  output logic [23:0] colour_o2,
  output logic [23:0] colour_o3,
  output logic [23:0] colour_o4,
  output logic [23:0] colour_o5,
  output logic [23:0] colour_o6,
  output logic [23:0] colour_o7,
  output logic [23:0] colour_o8,
  output logic        win_valid_o,
  output logic        frame_done_o
`ifdef WIN_COORD_EN
  ,
  output logic [11:0] win_x_o,
  output logic [11:0] win_y_o
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col, col_eff, col_nxt;
  logic [RW-1:0] row, row_eff, row_nxt;
  logic          accept;
  logic          col_last, row_last;
  logic [23:0]   lb0_rd, lb1_rd;

  // line_buf0 holds line row-1, line_buf1 holds line row-2
  logic [23:0] line_buf0 [IMG_WIDTH];
  logic [23:0] line_buf1 [IMG_WIDTH];

  // win[r*3+c]: r=0 top, c=0 left
  logic [23:0] win [9];

  assign accept = pix_valid_i & ~rst;

  // sof_i overrides the counters so a resync can happen mid-frame
  always_comb begin
    col_eff  = sof_i ? '0 : col;
    row_eff  = sof_i ? '0 : row;
    col_last = (col_eff == COL_LAST);
    row_last = (row_eff == ROW_LAST);
    col_nxt  = col_last ? '0 : col_eff + CW'(1);
    row_nxt  = row_eff;
    if (col_last) row_nxt = row_last ? '0 : row_eff + RW'(1);
  end

  assign lb0_rd = line_buf0[col_eff];
  assign lb1_rd = line_buf1[col_eff];

  // Buffers are never cleared; window gating keeps old contents unobservable
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf1[col_eff] <= lb0_rd;
      line_buf0[col_eff] <= pix_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
`ifdef WIN_COORD_EN
      win_x_o      <= '0;
      win_y_o      <= '0;
`endif
    end else begin
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      if (accept) begin
        col <= col_nxt;
        row <= row_nxt;
        for (int r = 0; r < 3; r++) begin
          win[r*3]   <= win[r*3+1];
          win[r*3+1] <= win[r*3+2];
        end
        win[2] <= lb1_rd;
        win[5] <= lb0_rd;
        win[8] <= pix_i;
        if (row_eff >= RW'(2) && col_eff >= CW'(2)) begin
          win_valid_o  <= 1'b1;
          frame_done_o <= col_last & row_last;
`ifdef WIN_COORD_EN
          win_x_o      <= 12'(col_eff) - 12'd1;
          win_y_o      <= 12'(row_eff) - 12'd1;
`endif
        end
      end
    end
  end

  assign colour_o0 = win[0];
  assign colour_o1 = win[1];
  assign colour_o2 = win[2];
  assign colour_o3 = win[3];
  assign colour_o4 = win[4];
  assign colour_o5 = win[5];
  assign colour_o6 = win[6];
  assign colour_o7 = win[7];
  assign colour_o8 = win[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] pix;
  logic        pix_valid;
  logic        sof;
  logic [23:0] c0, c1, c2, c3, c4, c5, c6, c7, c8;
  logic        win_valid;
  logic        frame_done;
`ifdef WIN_COORD_EN
  logic [11:0] win_x, win_y;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  window_3x3_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk(clk), .rst(rst), .pix_i(pix), .pix_valid_i(pix_valid), .sof_i(sof),
    .colour_o0(c0), .colour_o1(c1), .colour_o2(c2), .colour_o3(c3),
    .colour_o4(c4), .colour_o5(c5), .colour_o6(c6), .colour_o7(c7),
    .colour_o8(c8), .win_valid_o(win_valid), .frame_done_o(frame_done)
`ifdef WIN_COORD_EN
    , .win_x_o(win_x), .win_y_o(win_y)
`endif
  );

  typedef struct {
    int end_pix;
    int w[9];
    bit fd;
    int x;
    int y;
  } vec_t;

  typedef struct {
    int w[9];
    bit fd;
    int x;
    int y;
  } got_t;

  vec_t vecs[4];
  got_t q[$];
  logic last_acc = 1'b0;

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // Monitor: capture windows, and require silence on cycles with no accepted pixel
  always @(posedge clk) last_acc <= pix_valid & ~rst;

  always @(negedge clk) begin
    if (!last_acc)
      check(win_valid == 1'b0 && frame_done == 1'b0, "idle_quiet",
            $sformatf("got valid=%0b done=%0b, required 0/0", win_valid, frame_done));
    if (win_valid) begin
      got_t g;
      g.w  = '{int'(c0), int'(c1), int'(c2), int'(c3), int'(c4),
               int'(c5), int'(c6), int'(c7), int'(c8)};
      g.fd = frame_done;
`ifdef WIN_COORD_EN
      g.x = int'(win_x);
      g.y = int'(win_y);
`else
      g.x = 0;
      g.y = 0;
`endif
      q.push_back(g);
    end
  end

  task automatic send(input int v, input bit s, input int idle);
    pix       = 24'(v);
    sof       = s;
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic check_frame(input int off, input string name);
    repeat (3) @(negedge clk);
    check(q.size() == 4, {name, "_count"},
          $sformatf("got %0d windows, required 4", q.size()));
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      bit ok = (q[i].fd == vecs[i].fd);
      string gs = "", es = "";
      for (int k = 0; k < 9; k++) begin
        if (q[i].w[k] != vecs[i].w[k] + off) ok = 1'b0;
        gs = {gs, $sformatf("%0d ", q[i].w[k])};
        es = {es, $sformatf("%0d ", vecs[i].w[k] + off)};
      end
`ifdef WIN_COORD_EN
      if (q[i].x != vecs[i].x || q[i].y != vecs[i].y) ok = 1'b0;
`endif
      check(ok, $sformatf("%s_win%0d_end%0d", name, i, vecs[i].end_pix + off),
            $sformatf("got w=%s fd=%0b xy=(%0d,%0d), required w=%s fd=%0b xy=(%0d,%0d)",
                      gs, q[i].fd, q[i].x, q[i].y, es, vecs[i].fd, vecs[i].x, vecs[i].y));
    end
  endtask

  task automatic check_zero(input string name);
    check({c0, c1, c2, c3, c4, c5, c6, c7, c8} == '0 && !win_valid && !frame_done, name,
          $sformatf("got o0=%0d o4=%0d o8=%0d valid=%0b done=%0b, required all 0",
                    c0, c4, c8, win_valid, frame_done));
  endtask

  initial begin
    vecs[0] = '{end_pix: 10, w: '{0, 1, 2, 4, 5, 6, 8, 9, 10},    fd: 0, x: 1, y: 1};
    vecs[1] = '{end_pix: 11, w: '{1, 2, 3, 5, 6, 7, 9, 10, 11},   fd: 0, x: 2, y: 1};
    vecs[2] = '{end_pix: 14, w: '{4, 5, 6, 8, 9, 10, 12, 13, 14}, fd: 0, x: 1, y: 2};
    vecs[3] = '{end_pix: 15, w: '{5, 6, 7, 9, 10, 11, 13, 14, 15}, fd: 1, x: 2, y: 2};

    rst = 1'b1; pix = '0; pix_valid = 1'b0; sof = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back frame
    q.delete();
    for (int i = 0; i < 16; i++) send(i, i == 0, 0);
    check_frame(0, "b2b");

    // Random idle gaps
    q.delete();
    for (int i = 0; i < 16; i++) send(i, i == 0, int'($urandom_range(5, 0)));
    check_frame(0, "gaps");

    // Mid-frame resync: sof on the 7th pixel
    q.delete();
    for (int i = 0; i < 6; i++) send(i, i == 0, 0);
    for (int i = 0; i < 16; i++) send(100 + i, i == 0, 0);
    check_frame(100, "resync");
    begin
      int stale = 0;
      foreach (q[i]) for (int k = 0; k < 9; k++) if (q[i].w[k] < 6) stale++;
      check(stale == 0, "resync_no_stale",
            $sformatf("got %0d stale values, required 0", stale));
    end

    // Reset mid-frame, pix_valid held high during reset must be ignored
    q.delete();
    for (int i = 0; i < 10; i++) send(i, i == 0, 0);
    rst = 1'b1; pix_valid = 1'b1; pix = 24'd77;
    @(negedge clk);
    check_zero("mid_reset");
    rst = 1'b0; pix_valid = 1'b0;
    for (int i = 0; i < 16; i++) send(i, 1'b0, 0);
    check_frame(0, "after_reset");

    // Next frame follows without sof after the counters wrap
    q.delete();
    for (int i = 0; i < 16; i++) send(200 + i, 1'b0, 0);
    check_frame(200, "wrap");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
